// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings (burst, response, size) and the address-window classifier.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi3_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam logic [2:0] SIZE_4B = 3'b010;

  // Classify a whole burst at address time. Unsupported size/WRAP is a slave
  // error; any beat falling outside [base, base + 4*2^addr_bits) is a decode
  // error. 33-bit arithmetic keeps the end-of-burst sum from wrapping.
  function automatic resp_t classify(
    input logic [31:0] addr,
    input logic [3:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst,
    input logic [31:0] base,
    input int unsigned addr_bits
  );
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] start;
    logic [32:0] stop;
    lo    = {1'b0, base};
    hi    = lo + (33'd4 << addr_bits);
    start = {1'b0, addr} & ~33'd3;
    stop  = start + (({29'd0, len} + 33'd1) << 2);
    if (size != SIZE_4B || burst == BURST_WRAP) return RESP_SLVERR;
    if (start < lo) return RESP_DECERR;
    if (burst == BURST_FIXED) return (start >= hi) ? RESP_DECERR : RESP_OKAY;
    return (stop > hi) ? RESP_DECERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_word_ram.sv
// 32-bit word RAM with byte-enabled synchronous write and asynchronous read.
// Latency: writes land at the clock edge; reads are combinational (old value until that edge).
// Backpressure: none; a write is taken every cycle wr_en is high.
module axi_word_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [3:0]           wr_be,
  input  logic [31:0]          wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rd_data
);

  logic [31:0] mem [1 << ADDR_BITS];

  // Byte-lane write; lanes with a clear enable keep their contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi3_ram_responder.sv
// AXI3 slave over a word RAM; independent read and write channels, one burst each in flight.
// Latency: AW->wready +1 cycle, last W->bvalid +1, AR->rvalid +1 (combinational RAM read).
// Backpressure: rvalid/bvalid and their payloads hold until rready/bready; wready stays high during the data phase.
module axi3_ram_responder
  import axi3_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [5:0]  awid,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic [3:0]  awqos,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic [5:0]  wid,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [5:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [5:0]  arid,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic [3:0]  arqos,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [5:0]  rid,
  output logic        rlast
);

  // Sideband attributes and wid carry nothing this target acts on.
  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, awqos, arlock, arcache, arprot, arqos, wid};

  w_state_t             w_state, w_state_nxt;
  logic [ADDR_BITS-1:0] w_word;
  logic [3:0]           w_len, w_cnt;
  logic [5:0]           w_id;
  logic                 w_fixed;
  resp_t                w_class;
  logic                 w_lerr;

  r_state_t             r_state, r_state_nxt;
  logic [ADDR_BITS-1:0] r_word;
  logic [3:0]           r_len, r_cnt;
  logic [5:0]           r_id;
  logic                 r_fixed;
  resp_t                r_class;

  logic        aw_fire, w_fire, ar_fire, r_fire;
  logic [31:0] ram_rdata;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  // Write channel next state and handshake outputs.
  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !reset;
        if (awvalid && !reset) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_cnt == w_len) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Capture the write burst on AW, then step word/count on each accepted W beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_word  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
      w_fixed <= 1'b0;
      w_class <= RESP_OKAY;
      w_lerr  <= 1'b0;
    end else if (aw_fire) begin
      w_word  <= awaddr[ADDR_BITS+1:2];
      w_len   <= awlen;
      w_cnt   <= '0;
      w_id    <= awid;
      w_fixed <= (awburst == BURST_FIXED);
      w_class <= classify(awaddr, awlen, awsize, awburst, BASE, ADDR_BITS);
      w_lerr  <= 1'b0;
    end else if (w_fire) begin
      w_cnt <= w_cnt + 4'd1;
      if (!w_fixed) w_word <= w_word + ADDR_BITS'(1);
      if (wlast != (w_cnt == w_len)) w_lerr <= 1'b1;
    end
  end

  // A misplaced wlast only downgrades an otherwise good burst; data is still written.
  assign bresp = (w_class == RESP_OKAY && w_lerr) ? RESP_SLVERR : w_class;
  assign bid   = w_id;

  // Read channel next state and handshake outputs.
  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = !reset;
        if (arvalid && !reset) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && r_cnt == r_len) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Capture the read burst on AR, then step word/count on each accepted R beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_fixed <= 1'b0;
      r_class <= RESP_OKAY;
    end else if (ar_fire) begin
      r_word  <= araddr[ADDR_BITS+1:2];
      r_len   <= arlen;
      r_cnt   <= '0;
      r_id    <= arid;
      r_fixed <= (arburst == BURST_FIXED);
      r_class <= classify(araddr, arlen, arsize, arburst, BASE, ADDR_BITS);
    end else if (r_fire) begin
      r_cnt <= r_cnt + 4'd1;
      if (!r_fixed) r_word <= r_word + ADDR_BITS'(1);
    end
  end

  assign rdata = (rvalid && r_class == RESP_OKAY) ? ram_rdata : 32'd0;
  assign rresp = r_class;
  assign rid   = r_id;
  assign rlast = rvalid && (r_cnt == r_len);

  axi_word_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clock   (clock),
    .wr_en   (w_fire && w_class == RESP_OKAY),
    .wr_addr (w_word),
    .wr_be   (wstrb),
    .wr_data (wdata),
    .rd_addr (r_word),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_axi3_ram_responder.sv
// Randomized bench for axi3_ram_responder against a word-array memory model.
// Latency: checks AW->wready, W->bvalid, B->awready, AR->rvalid, R->arready spacing.
// Backpressure: bready/rready driven always-on, random or alternating.
module tb_axi3_ram_responder;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          ADDR_BITS = 8;
  localparam int          DEPTH     = 1 << ADDR_BITS;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [5:0]  id;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [5:0] id;
  } bbeat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic [5:0]  awid = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic [5:0]  arid = 0;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [5:0]  rid;
  logic        rlast;

  always #5 clock = ~clock;

  axi3_ram_responder #(.BASE(BASE), .ADDR_BITS(ADDR_BITS)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awqos(4'h0),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wid(6'd0),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arqos(4'h0),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid),
    .rlast(rlast)
  );

  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 1'b1;
  int          rr_mode = 0;
  int          br_mode = 0;
  logic [31:0] mem_m [DEPTH];
  rbeat_t      rexp_q[$];
  rbeat_t      r_got[$];
  bbeat_t      bexp_q[$];
  bbeat_t      b_got[$];
  logic [31:0] g_wd [16];
  logic [3:0]  g_ws [16];
  time         aw_hs_t, ar_hs_t;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endfunction

  function automatic void fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got=no-handshake expected=handshake", nm);
  endfunction

  // Response class from the rules: bad size or WRAP -> SLVERR; any beat address
  // outside the RAM window -> DECERR; otherwise OKAY.
  function automatic logic [1:0] m_class(input logic [31:0] addr, input int len,
                                         input logic [2:0] size, input logic [1:0] burst);
    longint a, lo, hi, b;
    a  = longint'({32'd0, addr & 32'hFFFF_FFFC});
    lo = longint'({32'd0, BASE});
    hi = lo + 4 * DEPTH;
    if (size != 3'b010 || burst == 2'b10) return 2'd2;
    for (int i = 0; i <= len; i++) begin
      b = a + ((burst == 2'b00) ? 0 : 4 * i);
      if (b < lo || b >= hi) return 2'd3;
    end
    return 2'd0;
  endfunction

  function automatic int m_index(input logic [31:0] addr, input int i, input logic [1:0] burst);
    return int'(((addr & 32'hFFFF_FFFC) - BASE) >> 2) + ((burst == 2'b00) ? 0 : i);
  endfunction

  // Ready generators for the response channels.
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = ~rready;
      endcase
      bready = (br_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every cycle a response is valid it must match the model's head entry.
  always @(negedge clock) begin
    rbeat_t re;
    bbeat_t be;
    if (cmp_en && !reset) begin
      if (rvalid) begin
        if (rexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected got=rvalid expected=idle");
        end else begin
          re = rexp_q[0];
          check("r_beat", 64'({rdata, rresp, rid, rlast}), 64'(re));
          if (rready) begin
            r_got.push_back({rdata, rresp, rid, rlast});
            void'(rexp_q.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (bexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected got=bvalid expected=idle");
        end else begin
          be = bexp_q[0];
          check("b_resp", 64'({bresp, bid}), 64'(be));
          if (bready) begin
            b_got.push_back({bresp, bid});
            void'(bexp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [5:0] id, input int bad_last);
    logic [1:0] cls;
    bit         lerr, hs;
    int         t, idx;
    cls  = m_class(addr, len, size, burst);
    lerr = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == bad_last) lerr = 1'b1;
      if (cls == 2'd0) begin
        idx = m_index(addr, i, burst);
        for (int k = 0; k < 4; k++)
          if (g_ws[i][k]) mem_m[idx][8*k +: 8] = g_wd[i][8*k +: 8];
      end
    end
    bexp_q.push_back({(cls == 2'd0 && lerr) ? 2'd2 : cls, id});

    @(posedge clock); #1;
    awvalid = 1'b1; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awid = id;
    t = 0;
    do begin @(negedge clock); hs = awready; @(posedge clock); #1; t++; end while (!hs && t < 100);
    awvalid = 1'b0;
    aw_hs_t = $time;
    if (!hs) begin fail_to("aw_timeout"); return; end

    for (int i = 0; i <= len; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      wvalid = 1'b1; wdata = g_wd[i]; wstrb = g_ws[i];
      wlast = ((i == len) != (i == bad_last));
      t = 0;
      do begin
        @(negedge clock);
        hs = wready;
        if (i == 0 && t == 0) check("aw_to_wready", 64'(wready), 64'(1));
        @(posedge clock); #1; t++;
      end while (!hs && t < 100);
      wvalid = 1'b0; wlast = 1'b0;
      if (!hs) begin fail_to("w_timeout"); return; end
    end

    @(negedge clock);
    check("w_to_bvalid", 64'(bvalid), 64'(1));
    t = 0;
    while (bexp_q.size() != 0 && t < 200) begin @(posedge clock); t++; end
    if (t >= 200) begin fail_to("b_timeout"); bexp_q.delete(); return; end
    @(negedge clock);
    check("b_to_awready", 64'(awready), 64'(1));
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [5:0] id);
    logic [1:0] cls;
    bit         hs;
    int         t;
    rbeat_t     e;
    cls = m_class(addr, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      e.data = (cls == 2'd0) ? mem_m[m_index(addr, i, burst)] : 32'd0;
      e.resp = cls;
      e.id   = id;
      e.last = (i == len);
      rexp_q.push_back(e);
    end

    @(posedge clock); #1;
    arvalid = 1'b1; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arid = id;
    t = 0;
    do begin @(negedge clock); hs = arready; @(posedge clock); #1; t++; end while (!hs && t < 100);
    arvalid = 1'b0;
    ar_hs_t = $time;
    if (!hs) begin fail_to("ar_timeout"); rexp_q.delete(); return; end

    @(negedge clock);
    check("ar_to_rvalid", 64'(rvalid), 64'(1));
    t = 0;
    while (rexp_q.size() != 0 && t < 300) begin @(posedge clock); t++; end
    if (t >= 300) begin fail_to("r_timeout"); rexp_q.delete(); return; end
    @(negedge clock);
    check("r_to_arready", 64'({arready, rvalid}), 64'(2'b10));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    int t;

    // Reset values.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'({awready, arready}), 64'(0));
    check("rst_valid", 64'({wready, bvalid, rvalid, rlast}), 64'(0));
    check("rst_resp",  64'({bresp, rresp, bid, rid}), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'({awready, arready}), 64'(2'b11));

    // Fill the RAM so every later read is defined.
    for (int i = 0; i < 16; i++) g_ws[i] = 4'hF;
    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int i = 0; i < 16; i++) g_wd[i] = $urandom;
      do_write(32'(b * 64), 15, 3'b010, 2'b01, 6'(b), -1);
    end

    // Single-beat write and read-back.
    b_got.delete(); r_got.delete();
    g_wd[0] = 32'hDEADBEEF; g_ws[0] = 4'hF;
    do_write(32'h10, 0, 3'b010, 2'b01, 6'd3, -1);
    do_read(32'h10, 0, 3'b010, 2'b01, 6'd5);
    check("single_bresp", 64'(b_got.size() > 0 ? b_got[0].resp : 2'd1), 64'(0));
    check("single_rbeat", 64'(r_got.size() > 0 ? r_got[0] : '0), 64'({32'hDEADBEEF, 2'd0, 6'd5, 1'b1}));

    // INCR write of 1..4, read back with rready alternating.
    for (int i = 0; i < 4; i++) begin g_wd[i] = 32'(i + 1); g_ws[i] = 4'hF; end
    do_write(32'h40, 3, 3'b010, 2'b01, 6'd7, -1);
    r_got.delete();
    rr_mode = 2;
    do_read(32'h40, 3, 3'b010, 2'b01, 6'd9);
    rr_mode = 0;
    check("incr_nbeats", 64'(r_got.size()), 64'(4));
    for (int i = 0; i < 4 && i < r_got.size(); i++)
      check("incr_beat", 64'({r_got[i].data, r_got[i].last}), 64'({32'(i + 1), 1'(i == 3)}));

    // Byte strobes merge into existing data.
    g_wd[0] = 32'h11223344; g_ws[0] = 4'hF;
    do_write(32'h20, 0, 3'b010, 2'b01, 6'd1, -1);
    g_wd[0] = 32'hAABBCCDD; g_ws[0] = 4'h5;
    do_write(32'h20, 0, 3'b010, 2'b01, 6'd1, -1);
    r_got.delete();
    do_read(32'h20, 0, 3'b010, 2'b00, 6'd2);
    check("strobe_merge", 64'(r_got.size() > 0 ? r_got[0].data : 32'd0), 64'(32'h11BB33DD));

    // Burst running off the top of the RAM, then a WRAP read.
    b_got.delete();
    for (int i = 0; i < 4; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'hF; end
    do_write(32'h3F8, 3, 3'b010, 2'b01, 6'd4, -1);
    check("decerr_bresp", 64'(b_got.size() > 0 ? b_got[0].resp : 2'd0), 64'(3));
    do_read(32'h3F8, 1, 3'b010, 2'b01, 6'd4);
    r_got.delete();
    do_read(32'h0, 3, 3'b010, 2'b10, 6'd8);
    check("wrap_nbeats", 64'(r_got.size()), 64'(4));
    for (int i = 0; i < 4 && i < r_got.size(); i++)
      check("wrap_beat", 64'({r_got[i].data, r_got[i].resp}), 64'({32'd0, 2'd2}));

    // Early wlast, then a FIXED burst hammering one word.
    b_got.delete();
    g_wd[0] = 32'hA; g_wd[1] = 32'hB; g_ws[0] = 4'hF; g_ws[1] = 4'hF;
    do_write(32'h80, 1, 3'b010, 2'b01, 6'd6, 0);
    check("wlast_slverr", 64'(b_got.size() > 0 ? b_got[0].resp : 2'd0), 64'(2));
    for (int i = 0; i < 3; i++) begin g_wd[i] = 32'(5 + i); g_ws[i] = 4'hF; end
    do_write(32'h8, 2, 3'b010, 2'b00, 6'd6, -1);
    r_got.delete();
    do_read(32'h8, 0, 3'b010, 2'b01, 6'd6);
    check("fixed_last", 64'(r_got.size() > 0 ? r_got[0].data : 32'd0), 64'(7));

    // AW and AR presented together on disjoint regions.
    for (int i = 0; i < 4; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'hF; end
    fork
      do_write(32'h200, 3, 3'b010, 2'b01, 6'd10, -1);
      do_read(32'h300, 3, 3'b010, 2'b01, 6'd11);
    join
    check("aw_ar_same_edge", 64'(aw_hs_t), 64'(ar_hs_t));

    // Randomized traffic with random backpressure.
    rr_mode = 1; br_mode = 1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [1:0]  bu;
      logic [2:0]  sz;
      int          len, bl, r;
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h3C0 + (32'($urandom_range(0, 31)) << 2);
      else        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      a = a | 32'($urandom_range(0, 3));
      len = $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      bu = (r < 6) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
      sz = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'($urandom); end
        bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        do_write(a, len, sz, bu, 6'($urandom), bl);
      end else begin
        do_read(a, len, sz, bu, 6'($urandom));
      end
    end
    rr_mode = 0; br_mode = 0;

    // Reset during the third beat of an eight-beat read.
    cmp_en = 1'b0;
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = 32'h100; arlen = 4'd7; arsize = 3'b010; arburst = 2'b01; arid = 6'd12;
    t = 0;
    do begin @(negedge clock); hs = arready; @(posedge clock); #1; t++; end while (!hs && t < 100);
    arvalid = 1'b0;
    if (!hs) fail_to("rst_ar_timeout");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_rvalid", 64'({rvalid, rlast, arready}), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_ready", 64'({arready, awready, rvalid}), 64'(3'b110));
    cmp_en = 1'b1;
    do_read(32'h100, 1, 3'b010, 2'b01, 6'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi3_ram_responder.md
# axi3_ram_responder

AXI3 slave (32-bit data, 6-bit IDs, 4-bit burst length) backed by a 2^ADDR_BITS-word register RAM. It is the responder end of the HP-port master interfaces, supplying a cycle-accurate target for the stimulator and DMA masters in simulation, and a small memory-mapped scratch RAM on the fabric. Read and write channels run independently, each with one transaction in flight, supporting FIXED and INCR bursts of 1–16 beats with byte strobes.

## Interface
- BASE, 32'h0000_0000, byte address of word 0; must be a multiple of 4*2^ADDR_BITS
- ADDR_BITS, 8, log2 of RAM depth in 32-bit words
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- awvalid/awready  in/out  1  write address handshake; awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awid in 6; awlock/awcache/awprot/awqos inputs present, ignored
- wvalid/wready  in/out  1  write data handshake; wdata in 32, wstrb in 4, wlast in 1; wid in 6 ignored (no interleaving)
- bvalid/bready  out/in  1  write response; bresp out 2, bid out 6
- arvalid/arready  in/out  1  read address; araddr in 32, arlen in 4, arsize in 3, arburst in 2, arid in 6; arlock/arcache/arprot/arqos ignored
- rvalid/rready  out/in  1  read data; rdata out 32, rresp out 2, rid out 6, rlast out 1

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; read FSM R_IDLE -> R_DATA -> R_IDLE.
- awready = (wstate==W_IDLE) && !reset; arready = (rstate==R_IDLE) && !reset.
- Address handshake captures addr, len, id, burst, size; beat counter cleared to 0.
- Error classification at capture, fixed for whole burst:
  - SLVERR: size != 3'b010 or burst == WRAP (2'b10).
  - else DECERR: addr < BASE, or addr + 4*(len+1) > BASE + 4*2^ADDR_BITS (INCR) / addr outside range (FIXED).
  - else OKAY. Low two address bits ignored (word aligned).
- W_DATA: wready=1; each wvalid beat writes bytes of mem[word] where wstrb[i]=1, only if burst is OKAY. INCR advances word by 1 per beat; FIXED holds. Beat with count==len -> W_RESP. wlast != (count==len) on any beat upgrades OKAY bresp to SLVERR (data still written).
- W_RESP: bvalid=1, bid=captured id; held stable until bready, then W_IDLE.
- R_DATA: rvalid=1, rdata = mem[word] (0 on error bursts), rresp=class, rid=captured id, rlast=(count==len); outputs stable until rready; handshake advances word/count; last handshake -> R_IDLE.
- RAM contents not reset; unwritten words read X.

## Timing
- Reset values: awready=arready=0 during reset, 1 first cycle after; wready=bvalid=rvalid=rlast=0; bresp=rresp=0; bid=rid=0.
- AW handshake at edge N -> wready high cycle N+1. Last W beat at edge M -> bvalid high cycle M+1. B handshake at edge K -> awready high cycle K+1. Min single-beat write: 3 cycles, addr to next awready.
- AR handshake at edge N -> first rvalid cycle N+1 (combinational RAM read); one beat per cycle at rready=1; last handshake at K -> arready K+1.
- Read/write same word same cycle: rdata shows pre-write value; new value from next cycle.
- Simultaneous AW and AR: both accepted same edge.
- Reset mid-burst: both FSMs to idle next edge, no B/R issued, partial writes retained.

## Structure
- Shared package axi3_pkg: burst enum (FIXED=0, INCR=1, WRAP=2), response enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), SIZE_4B=3'b010; reused by masters.
- Sub-module axi_word_ram: one write port with 4-bit byte enable, one asynchronous read port, ADDR_BITS parameter.

## Test plan
- Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR write len=3 at 0x40 data 1,2,3,4; INCR read len=3 with rready toggled every other cycle -> rdata 1,2,3,4, rlast only on 4th, values stable while stalled.
- Byte strobe: write 0xAABBCCDD wstrb=4'h5 over 0x11223344 -> reads 0x11BB33DD.
- awaddr=0x3F8, awlen=3 (ADDR_BITS=8, BASE=0) -> 4 wready beats, bresp=DECERR, no RAM change; arburst=WRAP -> 4 beats rresp=SLVERR, rdata=0.
- Write len=1 with wlast on first beat -> bresp=SLVERR after 2nd beat; FIXED write len=2 to 0x8 data 5,6,7 -> mem[0x8]=7.
- Reset asserted during 3rd beat of 8-beat read -> rvalid=0 next cycle, arready=1 cycle after reset deasserts.
